// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of the async FIFO feeding the CNN line
// buffers. Runs in the write clock domain, owns the binary/Gray write pointer,
// synchronises the read-domain Gray pointer and produces registered full and
// almost-full flags plus the RAM write address/enable.
//
// Optional feature macro: FIFO_WR_LEVEL_EN (adds the wlevel occupancy port).
//
// Ports:
//   clk          in   write-domain clock
//   rst          in   synchronous, active-low reset
//   w_en         in   write request from producer
//   rgray_async  in   read-domain Gray pointer (asynchronous to clk)
//   wgray        out  registered Gray write pointer, exported to read domain
//   waddr        out  RAM write address (binary pointer LSBs)
//   wclken       out  RAM write enable, w_en && !wfull (combinational)
//   wfull        out  registered full flag
//   walmost_full out  registered almost-full flag (free slots <= AF_MARGIN)
//   wlevel       out  write-side occupancy (FIFO_WR_LEVEL_EN only)
module fifo_wr_ctrl #(
  parameter int ADDR_BITS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [ADDR_BITS:0]   rgray_async,
  output logic [ADDR_BITS:0]   wgray,
  output logic [ADDR_BITS-1:0] waddr,
  output logic                 wclken,
  output logic                 wfull,
  output logic                 walmost_full
`ifdef FIFO_WR_LEVEL_EN
  ,
  output logic [ADDR_BITS:0]   wlevel
`endif
);

  localparam logic [ADDR_BITS+1:0] DEPTH_W = (ADDR_BITS+2)'(1) << ADDR_BITS;
  localparam logic [ADDR_BITS+1:0] AF_W    = (ADDR_BITS+2)'(AF_MARGIN);

  logic [ADDR_BITS:0]   wbin_q, wbin_d;
  logic [ADDR_BITS:0]   wgray_q, wgray_d;
  logic [ADDR_BITS:0]   rq_q [SYNC_STAGES];
  logic [ADDR_BITS:0]   rq_d [SYNC_STAGES];
  logic                 wfull_q, wfull_d;
  logic                 walmost_full_q, walmost_full_d;

  logic                 wclken_c;
  logic [ADDR_BITS:0]   rq_s;
  logic [ADDR_BITS:0]   rbin_s;
  logic [ADDR_BITS:0]   wbin_next;
  logic [ADDR_BITS:0]   wgray_next;
  logic [ADDR_BITS:0]   used_next;
  logic [ADDR_BITS+1:0] free_next;

  always_comb begin
    rq_s       = rq_q[SYNC_STAGES-1];
    wclken_c   = w_en && !wfull_q;
    wbin_next  = wbin_q + {{ADDR_BITS{1'b0}}, wclken_c};
    wgray_next = wbin_next ^ (wbin_next >> 1);

    // Gray to binary: running XOR from the MSB downwards.
    rbin_s            = '0;
    rbin_s[ADDR_BITS] = rq_s[ADDR_BITS];
    for (int unsigned i = 0; i < ADDR_BITS; i++) begin
      rbin_s[ADDR_BITS-1-i] = rbin_s[ADDR_BITS-i] ^ rq_s[ADDR_BITS-1-i];
    end

    used_next = wbin_next - rbin_s;
    free_next = DEPTH_W - {1'b0, used_next};
  end

  always_comb begin
    wbin_d         = wbin_next;
    wgray_d        = wgray_next;
    // Full when the write pointer is one whole pass ahead of the read pointer.
    wfull_d        = (wgray_next == {~rq_s[ADDR_BITS:ADDR_BITS-1], rq_s[ADDR_BITS-2:0]});
    walmost_full_d = (free_next <= AF_W);
    rq_d[0]        = rgray_async;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      rq_d[k] = rq_q[k-1];
    end
    if (!rst) begin
      wbin_d         = '0;
      wgray_d        = '0;
      wfull_d        = 1'b0;
      walmost_full_d = 1'b0;
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        rq_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    wbin_q         <= wbin_d;
    wgray_q        <= wgray_d;
    rq_q           <= rq_d;
    wfull_q        <= wfull_d;
    walmost_full_q <= walmost_full_d;
  end

`ifdef FIFO_WR_LEVEL_EN
  logic [ADDR_BITS:0] wlevel_q, wlevel_d;

  always_comb begin
    wlevel_d = used_next;
    if (!rst) begin
      wlevel_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    wlevel_q <= wlevel_d;
  end

  assign wlevel = wlevel_q;
`endif

  assign wgray        = wgray_q;
  assign waddr        = wbin_q[ADDR_BITS-1:0];
  assign wclken       = wclken_c;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios plus randomized
// traffic, compared against a count-based reference model.
module tb_fifo_wr_ctrl;

  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int AF    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_en = 1'b0;
  logic [AW:0]   rgray_async = '0;
  logic [AW:0]   wgray;
  logic [AW-1:0] waddr;
  logic          wclken;
  logic          wfull;
  logic          walmost_full;
`ifdef FIFO_WR_LEVEL_EN
  logic [AW:0]   wlevel;
`endif

  fifo_wr_ctrl #(.ADDR_BITS(AW), .SYNC_STAGES(SS), .AF_MARGIN(AF)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .rgray_async(rgray_async),
    .wgray(wgray), .waddr(waddr), .wclken(wclken), .wfull(wfull),
    .walmost_full(walmost_full)
`ifdef FIFO_WR_LEVEL_EN
    , .wlevel(wlevel)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: absolute counts of writes/reads, sync delay as a pipe.
  int   m_wcnt = 0;
  bit   m_full = 0;
  bit   m_af   = 0;
  int   m_lvl  = 0;
  int   sp [SS];
  bit   m_acc;
  logic s_wclken;
  bit   e_wclken;
  int   rd = 0;

  function automatic int gray_of(input int n);
    int v;
    v = n % PMOD;
    return v ^ (v >> 1);
  endfunction

  // Inverse Gray by search: the n whose Gray code matches.
  function automatic int bin_of(input int g);
    for (int n = 0; n < PMOD; n++) if (gray_of(n) == g) return n;
    return 0;
  endfunction

  function automatic logic [AW:0] exp_wgray();
    return (AW+1)'(gray_of(m_wcnt));
  endfunction

  function automatic logic [AW-1:0] exp_waddr();
    return AW'(m_wcnt % DEPTH);
  endfunction

  task automatic cycle(input logic r, input logic w, input logic [AW:0] g);
    int rp, used;
    rst = r; w_en = w; rgray_async = g;
    #1;
    s_wclken = wclken;
    e_wclken = w && !m_full;
    @(posedge clk);
    m_acc = 0;
    if (!r) begin
      m_wcnt = 0; m_full = 0; m_af = 0; m_lvl = 0;
      for (int i = 0; i < SS; i++) sp[i] = 0;
    end else begin
      rp = bin_of(sp[SS-1]);
      m_acc = w && !m_full;
      if (m_acc) m_wcnt++;
      used = ((m_wcnt % PMOD) - rp + PMOD) % PMOD;
      m_full = (used == DEPTH);
      m_af = ((DEPTH - used) <= AF);
      m_lvl = used;
      for (int i = SS - 1; i > 0; i--) sp[i] = sp[i-1];
      sp[0] = int'(g);
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, '0);
      checks++; if (s_wclken !== 1'b1) begin errors++; $display("FAIL reset_wclken: got %b want 1", s_wclken); end
      checks++; if (wgray !== '0) begin errors++; $display("FAIL reset_wgray: got %h want 0", wgray); end
      checks++; if (waddr !== '0) begin errors++; $display("FAIL reset_waddr: got %h want 0", waddr); end
      checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull: got %b want 0", wfull); end
      checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b want 0", walmost_full); end
`ifdef FIFO_WR_LEVEL_EN
      checks++; if (wlevel !== '0) begin errors++; $display("FAIL reset_wlevel: got %0d want 0", wlevel); end
`endif
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b1, '0);
      checks++; if (wgray !== exp_wgray()) begin errors++; $display("FAIL fill_wgray: write %0d got %h want %h", i, wgray, exp_wgray()); end
      checks++; if (waddr !== exp_waddr()) begin errors++; $display("FAIL fill_waddr: write %0d got %0d want %0d", i, waddr, exp_waddr()); end
      checks++; if (walmost_full !== m_af) begin errors++; $display("FAIL fill_af: write %0d got %b want %b", i, walmost_full, m_af); end
      checks++; if (wfull !== m_full) begin errors++; $display("FAIL fill_wfull: write %0d got %b want %b", i, wfull, m_full); end
      checks++; if (walmost_full !== (i >= DEPTH - AF)) begin errors++; $display("FAIL fill_af_point: write %0d got %b", i, walmost_full); end
    end
    checks++; if (wgray !== 5'b11000) begin errors++; $display("FAIL fill_final_wgray: got %b want 11000", wgray); end
    checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL fill_final_wfull: got %b want 1", wfull); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, '0);
      checks++; if (s_wclken !== 1'b0) begin errors++; $display("FAIL ovf_wclken: got %b want 0", s_wclken); end
      checks++; if (wgray !== 5'b11000) begin errors++; $display("FAIL ovf_wgray: got %b want 11000", wgray); end
      checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL ovf_waddr: got %0d want 0", waddr); end
      checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL ovf_wfull: got %b want 1", wfull); end
    end
  endtask

  task automatic test_drain_release();
    for (int i = 1; i <= SS + 1; i++) begin
      cycle(1'b1, 1'b0, 5'b00001);
      checks++; if (wfull !== (i <= SS)) begin errors++; $display("FAIL drain_wfull: cycle %0d got %b want %b", i, wfull, (i <= SS)); end
      checks++; if (walmost_full !== 1'b1) begin errors++; $display("FAIL drain_af: cycle %0d got %b want 1", i, walmost_full); end
`ifdef FIFO_WR_LEVEL_EN
      checks++; if (wlevel !== (i <= SS ? 5'd16 : 5'd15)) begin errors++; $display("FAIL drain_wlevel: cycle %0d got %0d", i, wlevel); end
`endif
    end
  endtask

  task automatic test_wrap();
    logic [AW:0] prev;
    int budget;
    cycle(1'b0, 1'b0, '0);
    rd = 0; prev = '0; budget = 0;
    while (m_wcnt < 40 && budget < 400) begin
      budget++;
      if (rd < m_wcnt && (m_wcnt - rd) > $urandom_range(1, 6)) rd++;
      cycle(1'b1, 1'($urandom_range(0, 9) < 7), (AW+1)'(gray_of(rd)));
      checks++; if (wgray !== exp_wgray()) begin errors++; $display("FAIL wrap_wgray: got %h want %h", wgray, exp_wgray()); end
      checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL wrap_wfull: got %b want 0", wfull); end
      checks++; if (walmost_full !== m_af) begin errors++; $display("FAIL wrap_af: got %b want %b", walmost_full, m_af); end
      if (m_acc) begin
        checks++; if ($countones(wgray ^ prev) != 1) begin errors++; $display("FAIL wrap_onebit: prev %b cur %b", prev, wgray); end
        checks++; if (wgray[AW] !== 1'((m_wcnt / DEPTH) % 2)) begin errors++; $display("FAIL wrap_msb: write %0d got %b", m_wcnt, wgray[AW]); end
      end
      prev = wgray;
    end
    checks++; if (m_wcnt < 40) begin errors++; $display("FAIL wrap_budget: only %0d writes of 40", m_wcnt); end
  endtask

  task automatic test_random();
    cycle(1'b0, 1'b0, '0);
    rd = 0;
    for (int i = 0; i < 400; i++) begin
      if (rd < m_wcnt && $urandom_range(0, 9) < 3) rd++;
      cycle(1'b1, 1'($urandom_range(0, 9) < 7), (AW+1)'(gray_of(rd)));
      checks++; if (s_wclken !== e_wclken) begin errors++; $display("FAIL rnd_wclken: got %b want %b", s_wclken, e_wclken); end
      checks++; if (wgray !== exp_wgray()) begin errors++; $display("FAIL rnd_wgray: got %h want %h", wgray, exp_wgray()); end
      checks++; if (waddr !== exp_waddr()) begin errors++; $display("FAIL rnd_waddr: got %0d want %0d", waddr, exp_waddr()); end
      checks++; if (wfull !== m_full) begin errors++; $display("FAIL rnd_wfull: got %b want %b", wfull, m_full); end
      checks++; if (walmost_full !== m_af) begin errors++; $display("FAIL rnd_af: got %b want %b", walmost_full, m_af); end
`ifdef FIFO_WR_LEVEL_EN
      checks++; if (int'(wlevel) != m_lvl) begin errors++; $display("FAIL rnd_wlevel: got %0d want %0d", wlevel, m_lvl); end
`endif
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 1'b0, '0);
    rd = 0;
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, '0);
    checks++; if (waddr !== 4'd9) begin errors++; $display("FAIL mid_pre_waddr: got %0d want 9", waddr); end
`ifdef FIFO_WR_LEVEL_EN
    checks++; if (wlevel !== 5'd9) begin errors++; $display("FAIL mid_pre_wlevel: got %0d want 9", wlevel); end
`endif
    cycle(1'b0, 1'b1, '0);
    checks++; if (wgray !== '0) begin errors++; $display("FAIL mid_wgray: got %h want 0", wgray); end
    checks++; if (waddr !== '0) begin errors++; $display("FAIL mid_waddr: got %0d want 0", waddr); end
    checks++; if (wfull !== 1'b0 || walmost_full !== 1'b0) begin errors++; $display("FAIL mid_flags: got %b%b want 00", wfull, walmost_full); end
`ifdef FIFO_WR_LEVEL_EN
    checks++; if (wlevel !== '0) begin errors++; $display("FAIL mid_wlevel: got %0d want 0", wlevel); end
`endif
    cycle(1'b1, 1'b1, '0);
    checks++; if (waddr !== 4'd1 || wgray !== 5'd1) begin errors++; $display("FAIL mid_first_write: waddr %0d wgray %h want 1 1", waddr, wgray); end
  endtask

  initial begin
    for (int i = 0; i < SS; i++) sp[i] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain_release();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the async FIFO that feeds the CNN line buffers. It runs entirely in the write clock domain and owns the write pointer in binary and Gray form. It brings the read-domain Gray pointer across through a 2-flop synchroniser and produces registered full and almost-full flags, the RAM write address and the RAM write enable. It is the counterpart to the read-side controller and exports its Gray write pointer to that domain.

Parameters:
ADDR_BITS, 4, FIFO address width; depth = 2**ADDR_BITS; pointers are ADDR_BITS+1 bits wide.
SYNC_STAGES, 2, synchroniser depth for rgray_async; legal values 2..4.
AF_MARGIN, 2, walmost_full asserts when free slots <= AF_MARGIN; legal range 1..2**ADDR_BITS-1.

Ports:
clk  in  1  write-domain clock.
rst  in  1  synchronous, active-low reset.
w_en  in  1  write request from producer.
rgray_async  in  ADDR_BITS+1  read-domain Gray pointer, asynchronous to clk.
wgray  out  ADDR_BITS+1  registered Gray write pointer, exported to the read domain.
waddr  out  ADDR_BITS  RAM write address (binary pointer LSBs).
wclken  out  1  RAM write enable, combinational: w_en && !wfull.
wfull  out  1  registered full flag.
walmost_full  out  1  registered almost-full flag.
wlevel  out  ADDR_BITS+1  occupancy seen by the write side (only when FIFO_WR_LEVEL_EN is defined).

Behaviour:
- Reset (rst==0 at posedge clk): wbin, wgray, all synchroniser stages, wfull, walmost_full and wlevel go to 0. waddr therefore reads 0. Reset has priority over w_en.
- Reset applied mid-operation clears everything in one cycle. Any write in progress that cycle is dropped. No partial state remains.
- Synchroniser: rq[0] <= rgray_async, rq[k] <= rq[k-1]. The last stage rq_s is the only value of the read pointer used. Its latency is SYNC_STAGES cycles.
- Accept: a write is accepted when wclken=1. Then wbin_next = wbin + 1, otherwise wbin_next = wbin.
- Wrap-around: arithmetic is modulo 2**(ADDR_BITS+1). The extra MSB toggles every pass through the RAM.
- wgray <= wbin_next ^ (wbin_next >> 1), registered in the same cycle as wbin. Exactly one bit changes per accepted write.
- waddr = wbin[ADDR_BITS-1:0]. Data presented with wclken is written at the current waddr.
- Full: wfull <= (gray(wbin_next) == {~rq_s[MSB:MSB-1], rq_s[MSB-2:0]}).
  - It asserts in the cycle after the write that fills the FIFO.
  - A write that arrives while full is ignored. Pointers and flags do not change.
- Free-space rule:
  - rbin_s = gray2bin(rq_s), an XOR prefix from the MSB.
  - used_next = wbin_next - rbin_s, at ADDR_BITS+1 bits.
  - walmost_full <= (2**ADDR_BITS - used_next) <= AF_MARGIN.
- Pessimism: flags deassert only after read-pointer movement has passed through the synchroniser. This takes SYNC_STAGES cycles plus 1 cycle for the flag register. Flags never under-report fullness.
- Simultaneous events:
  - Write accepted in the same cycle rq_s advances: both are used in the next-state computation, so the net used count is unchanged.
  - Full and a read arriving together: wfull clears on the first edge at which rq_s reflects the read.
- No state machine beyond the pointer, synchroniser and flag registers. All outputs except wclken are registered.

Optional Feature:
- Macro FIFO_WR_LEVEL_EN.
- When defined:
  - The wlevel port exists.
  - wlevel <= used_next, updated on the same edge as the flags, reset to 0.
  - Range is 0..2**ADDR_BITS.
- When undefined:
  - The port is omitted and the associated register is removed.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with w_en=1 -> wgray=0, waddr=0, wfull=0, walmost_full=0, wclken=1 but pointers stay 0.
- Fill: ADDR_BITS=4, rgray_async=0, w_en=1 for 16 cycles -> waddr steps 0..15; wgray sequence 0,1,3,2,6,...; walmost_full rises after write 14; wfull rises after write 16; wgray=5'b11000.
- Overflow: with wfull=1, hold w_en=1 for 5 cycles -> wclken=0, waddr and wgray unchanged, wfull stays 1.
- Drain release: from full, drive rgray_async=5'b00001 (one read) -> wfull=0 exactly SYNC_STAGES+1 cycles later; walmost_full stays 1; wlevel=15 when FIFO_WR_LEVEL_EN is defined.
- Wrap: 40 writes interleaved with matching read-pointer updates -> MSB of wgray toggles at writes 16 and 32; consecutive wgray values differ by exactly one bit; no spurious wfull.
- Mid-operation reset: at level 9, pulse rst=0 for 1 cycle -> all outputs 0 on the next edge; first write after reset lands at waddr=0.
